// File: rtl/status_led_pkg.sv
// ============================================================================
// Module : status_led_pkg
// Brief  : Shared LED mode encoding and per-channel configuration record.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package status_led_pkg;

    localparam int LED_ARG_W = 8;

    typedef enum logic [2:0] {
        LED_OFF     = 3'd0,
        LED_ON      = 3'd1,
        LED_BLINK   = 3'd2,
        LED_STRETCH = 3'd3,
        LED_PWM     = 3'd4
    } led_mode_e;

    typedef struct packed {
        led_mode_e              mode;
        logic [LED_ARG_W-1:0]   arg;
    } led_cfg_t;

endpackage

`default_nettype wire

// File: rtl/status_led_channel.sv
// ============================================================================
// Module : status_led_channel
// Brief  : One LED channel: mode/arg register, blink and stretch timing.
//          PWM compare present only when STATUS_LED_PWM_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module status_led_channel
    import status_led_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_tick,
    input  logic                 i_cfg_we,
    input  logic [2:0]           i_cfg_mode,
    input  logic [LED_ARG_W-1:0] i_cfg_arg,
    input  logic                 i_event,
    input  logic [7:0]           i_pwm_cnt,
    output logic                 o_led
);

    led_cfg_t               r_cfg;
    logic [LED_ARG_W-1:0]   r_cnt;
    logic                   r_phase;
    logic [LED_ARG_W:0]     r_stretch;
    logic                   r_evt_d;
    logic                   w_rise;

    assign w_rise = i_event & ~r_evt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg.mode <= LED_OFF;
            r_cfg.arg  <= '0;
            r_cnt      <= '0;
            r_phase    <= 1'b0;
            r_stretch  <= '0;
            r_evt_d    <= 1'b0;
        end else begin
            r_evt_d <= i_event;
            // A write restarts the channel and swallows a coincident event edge
            if (i_cfg_we) begin
                r_cfg.mode <= led_mode_e'(i_cfg_mode);
                r_cfg.arg  <= i_cfg_arg;
                r_cnt      <= '0;
                r_phase    <= 1'b0;
                r_stretch  <= '0;
            end else begin
                if (r_cfg.mode == LED_BLINK && i_tick) begin
                    if (r_cnt == r_cfg.arg) begin
                        r_phase <= ~r_phase;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                if (w_rise && r_cfg.mode == LED_STRETCH) begin
                    r_stretch <= {1'b0, r_cfg.arg} + 1'b1;
                end else if (i_tick && r_stretch != '0) begin
                    r_stretch <= r_stretch - 1'b1;
                end
            end
        end
    end

`ifndef STATUS_LED_PWM_EN
    logic w_unused_pwm;
    assign w_unused_pwm = ^i_pwm_cnt;
`endif

    always_comb begin
        o_led = 1'b0;
        case (r_cfg.mode)
            LED_ON:      o_led = 1'b1;
            LED_BLINK:   o_led = r_phase;
            LED_STRETCH: o_led = (r_stretch != '0);
`ifdef STATUS_LED_PWM_EN
            LED_PWM:     o_led = (i_pwm_cnt < r_cfg.arg);
`endif
            default:     o_led = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/status_led_ctrl.sv
// ============================================================================
// Module : status_led_ctrl
// Brief  : Multi-channel status LED controller with tick prescaler and
//          SoC exit-status override. Optional PWM via STATUS_LED_PWM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module status_led_ctrl
    import status_led_pkg::*;
#(
    parameter  int NUM_LEDS         = 8,
    parameter  int TICK_DIV         = 1250000,
    parameter  int EXIT_BLINK_TICKS = 25,
    localparam int IDXW             = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic [IDXW-1:0]      cfg_idx_i,
    input  logic [2:0]           cfg_mode_i,
    input  logic [LED_ARG_W-1:0] cfg_arg_i,
    input  logic [NUM_LEDS-1:0]  event_i,
    input  logic                 exit_valid_i,
    input  logic                 exit_value_i,
    output logic                 tick_o,
    output logic [NUM_LEDS-1:0]  led_o
);

    localparam int                   c_PRESC_W  = $clog2(TICK_DIV);
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);
    localparam int                   c_EXIT_W   = $clog2(EXIT_BLINK_TICKS + 1);
    localparam logic [c_EXIT_W-1:0]  c_EXIT_MAX = c_EXIT_W'(EXIT_BLINK_TICKS - 1);
    localparam logic [IDXW:0]        c_NUM_LEDS = (IDXW + 1)'(NUM_LEDS);

    logic [c_PRESC_W-1:0] r_presc;
    logic                 r_tick;
    logic [7:0]           w_pwm_cnt;
    logic                 w_idx_ok;
    logic [NUM_LEDS-1:0]  w_we;
    logic [NUM_LEDS-1:0]  w_raw;
    logic                 r_exit_latched;
    logic                 r_exit_code;
    logic                 r_exit_phase;
    logic [c_EXIT_W-1:0]  r_exit_cnt;
    logic                 w_over_active;
    logic                 w_over_led;
    logic [NUM_LEDS-1:0]  r_led;

    // Tick is registered so its first pulse lands TICK_DIV cycles after reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick  <= (r_presc == c_PRESC_MAX);
            r_presc <= (r_presc == c_PRESC_MAX) ? '0 : r_presc + 1'b1;
        end
    end

`ifdef STATUS_LED_PWM_EN
    logic [7:0] r_pwm_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end
    assign w_pwm_cnt = r_pwm_cnt;
`else
    assign w_pwm_cnt = '0;
`endif

    assign w_idx_ok = ({1'b0, cfg_idx_i} < c_NUM_LEDS);

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        assign w_we[g] = cfg_we_i && w_idx_ok && (cfg_idx_i == IDXW'(g));

        status_led_channel u_chan (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .i_tick     (r_tick),
            .i_cfg_we   (w_we[g]),
            .i_cfg_mode (cfg_mode_i),
            .i_cfg_arg  (cfg_arg_i),
            .i_event    (event_i[g]),
            .i_pwm_cnt  (w_pwm_cnt),
            .o_led      (w_raw[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_exit_latched <= 1'b0;
            r_exit_code    <= 1'b0;
            r_exit_phase   <= 1'b0;
            r_exit_cnt     <= '0;
        end else if (!r_exit_latched) begin
            if (exit_valid_i) begin
                r_exit_latched <= 1'b1;
                r_exit_code    <= exit_value_i;
                r_exit_phase   <= 1'b1;
                r_exit_cnt     <= '0;
            end
        end else if (r_tick) begin
            if (r_exit_cnt == c_EXIT_MAX) begin
                r_exit_phase <= ~r_exit_phase;
                r_exit_cnt   <= '0;
            end else begin
                r_exit_cnt <= r_exit_cnt + 1'b1;
            end
        end
    end

    // Override takes effect in the same cycle as the latch so led_o follows next cycle
    assign w_over_active = r_exit_latched | exit_valid_i;
    assign w_over_led    = r_exit_latched ? (r_exit_code ? r_exit_phase : 1'b1) : 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_led <= '0;
        end else begin
            r_led <= w_over_active ? {NUM_LEDS{w_over_led}} : w_raw;
        end
    end

    assign tick_o = r_tick;
    assign led_o  = r_led;

endmodule

`default_nettype wire
